// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - MIPS instruction-fetch stage with IF/ID pipeline register
//
// Purpose:
//   Holds the PC, presents it to instruction memory, and captures the fetched
//   instruction plus PC+4 into the IF/ID register. Redirects the PC on a taken
//   jump or branch decoded in ID, inserts a single bubble on a redirect, and
//   freezes on a load-use stall or when the core is not running.
//
// Optional feature macro: FETCH_PERF_CNT_EN
//   When defined, adds saturating stall/flush performance counters.
//
// Ports:
//   clk_i         in   1   clock
//   rst_i         in   1   asynchronous active-low reset
//   start_i       in   1   run enable; low freezes fetch and feeds bubbles
//   stall_i       in   1   hold PC and IF/ID
//   branch_i      in   1   Branch control for the instruction in ID
//   jump_i        in   1   Jump control for the instruction in ID
//   eq_i          in   1   ID-stage rs==rt result
//   imem_data_i   in   32  instruction read combinationally at imem_addr_o
//   imem_addr_o   out  32  current PC
//   ifid_instr_o  out  32  IF/ID instruction
//   ifid_pc4_o    out  32  IF/ID PC+4
//   ifid_valid_o  out  1   IF/ID holds a real instruction
//   redirect_o    out  1   a jump/branch redirect is taken this cycle
//   stall_cnt_o   out  CNT_W  (FETCH_PERF_CNT_EN) stall cycles, saturating
//   flush_cnt_o   out  CNT_W  (FETCH_PERF_CNT_EN) redirects, saturating

module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_W     = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             branch_i,
    input  logic             jump_i,
    input  logic             eq_i,
    input  logic [31:0]      imem_data_i,
    output logic [31:0]      imem_addr_o,
    output logic [31:0]      ifid_instr_o,
    output logic [31:0]      ifid_pc4_o,
    output logic             ifid_valid_o,
    output logic             redirect_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
`endif
);

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_jtarget;
    logic [31:0] w_boffset;
    logic [31:0] w_btarget;
    logic        w_run;
    logic        w_take_j;
    logic        w_take_b;

    assign w_pc_plus4 = r_pc + 32'd4;

    // Targets are computed from the instruction sitting in IF/ID, not from
    // the instruction currently being fetched.
    assign w_jtarget = {r_pc4[31:28], r_instr[25:0], 2'b00};
    assign w_boffset = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
    assign w_btarget = r_pc4 + w_boffset;

    // A bubble in IF/ID (valid=0) must never redirect, whatever the decoder
    // makes of the NOP encoding.
    assign w_run    = start_i & ~stall_i & r_valid;
    assign w_take_j = w_run & jump_i;
    assign w_take_b = w_run & branch_i & eq_i;

    assign redirect_o = w_take_j | w_take_b;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_pc    <= RESET_PC;
            r_instr <= NOP_INSTR;
            r_pc4   <= 32'd0;
            r_valid <= 1'b0;
        end else if (!start_i) begin
            r_instr <= NOP_INSTR;
            r_pc4   <= 32'd0;
            r_valid <= 1'b0;
        end else if (stall_i) begin
            // Stall takes priority over any redirect: everything holds.
        end else if (w_take_j) begin
            r_pc    <= w_jtarget;
            r_instr <= NOP_INSTR;
            r_pc4   <= 32'd0;
            r_valid <= 1'b0;
        end else if (w_take_b) begin
            r_pc    <= w_btarget;
            r_instr <= NOP_INSTR;
            r_pc4   <= 32'd0;
            r_valid <= 1'b0;
        end else begin
            r_pc    <= w_pc_plus4;
            r_instr <= imem_data_i;
            r_pc4   <= w_pc_plus4;
            r_valid <= 1'b1;
        end
    end

    assign imem_addr_o  = r_pc;
    assign ifid_instr_o = r_instr;
    assign ifid_pc4_o   = r_pc4;
    assign ifid_valid_o = r_valid;

`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Both counters stop at all-ones rather than wrapping.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (start_i && stall_i && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (redirect_o && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`else
    wire [CNT_W-1:0] w_cnt_unused = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit

module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        stall_i;
    logic        branch_i;
    logic        jump_i;
    logic        eq_i;
    logic [31:0] imem_data_i;
    logic [31:0] imem_addr_o;
    logic [31:0] ifid_instr_o;
    logic [31:0] ifid_pc4_o;
    logic        ifid_valid_o;
    logic        redirect_o;
`ifdef FETCH_PERF_CNT_EN
    logic [2:0]  stall_cnt_o;
    logic [2:0]  flush_cnt_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:127];

    always #5 clk_i = ~clk_i;

    assign imem_data_i = (imem_addr_o < 32'd512) ? mem[imem_addr_o[8:2]]
                                                 : {imem_addr_o[31:8], 8'hAA};

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000),
`ifdef FETCH_PERF_CNT_EN
        .CNT_W     (3)
`else
        .CNT_W     (32)
`endif
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .stall_i      (stall_i),
        .branch_i     (branch_i),
        .jump_i       (jump_i),
        .eq_i         (eq_i),
        .imem_data_i  (imem_data_i),
        .imem_addr_o  (imem_addr_o),
        .ifid_instr_o (ifid_instr_o),
        .ifid_pc4_o   (ifid_pc4_o),
        .ifid_valid_o (ifid_valid_o),
        .redirect_o   (redirect_o)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cnt_o  (stall_cnt_o),
        .flush_cnt_o  (flush_cnt_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                              input logic [31:0] pc4, input logic valid);
        check({tag, ".pc"},    imem_addr_o,           pc);
        check({tag, ".instr"}, ifid_instr_o,          instr);
        check({tag, ".pc4"},   ifid_pc4_o,            pc4);
        check({tag, ".valid"}, {31'd0, ifid_valid_o}, {31'd0, valid});
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h0000_0020;
        mem[0]  = 32'h2008_0005;
        mem[1]  = 32'h2009_0003;
        mem[3]  = 32'h1000_FFFF;   // beq imm=-1 at 0xC
        mem[4]  = 32'h0800_0040;   // j 0x100 at 0x10
        mem[64] = 32'h1000_FFBE;   // beq at 0x100, target 0xFFFFFFFC

        rst_i = 1'b0; start_i = 1'b0; stall_i = 1'b0;
        branch_i = 1'b0; jump_i = 1'b0; eq_i = 1'b0;
        #3;
        check_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        check("reset_hold.pc", imem_addr_o, 32'h0);
        rst_i = 1'b1; start_i = 1'b1;
        #1;
        check("first_addr", imem_addr_o, 32'h0);

        // Sequential fetch
        tick(); check_ifid("seq1", 32'h4, 32'h2008_0005, 32'h4, 1'b1);
        tick(); check_ifid("seq2", 32'h8, 32'h2009_0003, 32'h8, 1'b1);
        tick(); check("seq3.pc", imem_addr_o, 32'hC);
        tick(); check_ifid("seq4", 32'h10, 32'h1000_FFFF, 32'h10, 1'b1);

        // Taken branch: 0x10 + (-4) = 0xC
        branch_i = 1'b1; eq_i = 1'b1; #1;
        check("br_taken.redirect", {31'd0, redirect_o}, 32'd1);
        tick(); check_ifid("br_bubble", 32'hC, 32'h0, 32'h0, 1'b0);
        check("br_bubble.masked", {31'd0, redirect_o}, 32'd0);
        tick(); check_ifid("br_refetch", 32'h10, 32'h1000_FFFF, 32'h10, 1'b1);

        // Untaken branch
        eq_i = 1'b0; #1;
        check("br_untaken.redirect", {31'd0, redirect_o}, 32'd0);
        tick(); check_ifid("br_untaken", 32'h14, 32'h0800_0040, 32'h14, 1'b1);

        // Stall beats redirect, jump beats branch
        jump_i = 1'b1; branch_i = 1'b1; eq_i = 1'b1; stall_i = 1'b1; #1;
        check("stall.redirect", {31'd0, redirect_o}, 32'd0);
        tick(); check_ifid("stall1", 32'h14, 32'h0800_0040, 32'h14, 1'b1);
        tick(); check_ifid("stall2", 32'h14, 32'h0800_0040, 32'h14, 1'b1);
        stall_i = 1'b0; #1;
        check("jump.redirect", {31'd0, redirect_o}, 32'd1);
        tick(); check_ifid("jump_bubble", 32'h100, 32'h0, 32'h0, 1'b0);
        jump_i = 1'b0; branch_i = 1'b0; eq_i = 1'b0;
        tick(); check_ifid("jump_target", 32'h104, 32'h1000_FFBE, 32'h104, 1'b1);

        // Branch to 0xFFFFFFFC then wrap to 0
        branch_i = 1'b1; eq_i = 1'b1; #1;
        check("br_far.redirect", {31'd0, redirect_o}, 32'd1);
        tick(); check_ifid("br_far", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
        branch_i = 1'b0; eq_i = 1'b0;
        tick(); check_ifid("wrap", 32'h0, 32'hFFFF_FFAA, 32'h0, 1'b1);

        // start low: frozen PC, bubble, redirect ignored
        start_i = 1'b0; jump_i = 1'b1; #1;
        check("idle.redirect", {31'd0, redirect_o}, 32'd0);
        tick(); check_ifid("idle", 32'h0, 32'h0, 32'h0, 1'b0);
        start_i = 1'b1; jump_i = 1'b0;
        tick(); check_ifid("resume", 32'h4, 32'h2008_0005, 32'h4, 1'b1);

        // Reset asserted mid-stall acts without a clock edge
        stall_i = 1'b1;
        tick(); check("pre_rst.pc", imem_addr_o, 32'h4);
        rst_i = 1'b0; #2;
        check_ifid("async_rst", 32'h0, 32'h0, 32'h0, 1'b0);
        tick(); check_ifid("rst_held", 32'h0, 32'h0, 32'h0, 1'b0);
        rst_i = 1'b1; stall_i = 1'b0;
        tick(); check_ifid("post_rst", 32'h4, 32'h2008_0005, 32'h4, 1'b1);

`ifdef FETCH_PERF_CNT_EN
        check("cnt.stall0", {29'd0, stall_cnt_o}, 32'd0);
        check("cnt.flush0", {29'd0, flush_cnt_o}, 32'd0);
        stall_i = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        check("cnt.stall7", {29'd0, stall_cnt_o}, 32'd7);
        tick(); tick();
        check("cnt.stall_sat", {29'd0, stall_cnt_o}, 32'd7);
        stall_i = 1'b0; jump_i = 1'b1;
        tick();
        tick();
        jump_i = 1'b0;
        tick();
        jump_i = 1'b1;
        tick();
        jump_i = 1'b0;
        check("cnt.flush2", {29'd0, flush_cnt_o}, 32'd2);
        check("cnt.stall_keep", {29'd0, stall_cnt_o}, 32'd7);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
